taxi_eth_phy_10g_tx_gbx_66_64: RTL and testbench

// 66:64 TX gearbox between the 10GBASE-R TX interface (scrambled 64b data + 2b sync header) and a 64-bit SERDES without a native gearbox.

---
 rtl/taxi_eth_phy_pkg.sv | 21 ++
 rtl/taxi_eth_gbx_seq.sv | 55 +++++
 rtl/taxi_eth_phy_10g_tx_gbx_66_64.sv | 141 ++++++++++++++
 tb/tb_taxi_eth_phy_10g_tx_gbx_66_64.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_eth_phy_pkg.sv
// +----------------------------------------------------------------------+
// | taxi_eth_phy_pkg: shared constants and types for the 66:64 gearbox   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package taxi_eth_phy_pkg;

    localparam int GBX_SEQ_LEN   = 33;
    localparam int GBX_BLOCK_W   = 66;
    localparam int GBX_LAST_SLOT = GBX_SEQ_LEN - 1;

    typedef logic [5:0] gbx_slot_t;

    function automatic gbx_slot_t gbx_slot_next(input gbx_slot_t slot);
        return (slot == gbx_slot_t'(GBX_LAST_SLOT)) ? '0 : slot + 6'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/taxi_eth_gbx_seq.sv
// +----------------------------------------------------------------------+
// | taxi_eth_gbx_seq: free-running 33-slot counter with registered       |
// | start/stall requests issued STALL_LEAD cycles ahead of the slot.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module taxi_eth_gbx_seq
    import taxi_eth_phy_pkg::*;
#(
    parameter int STALL_LEAD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] slot_o,
    output logic       req_start_o,
    output logic       req_stall_o
);

    localparam gbx_slot_t STALL_SLOT = gbx_slot_t'(GBX_SEQ_LEN - 1 - STALL_LEAD);
    localparam gbx_slot_t START_SLOT = gbx_slot_t'((GBX_SEQ_LEN - STALL_LEAD) % GBX_SEQ_LEN);

    if (STALL_LEAD < 1 || STALL_LEAD > 16) begin : g_bad_stall_lead
        $fatal(1, "STALL_LEAD must be in 1..16");
    end

    gbx_slot_t slot_q;
    gbx_slot_t slot_d;
    logic      req_start_q;
    logic      req_stall_q;

    always_comb begin
        slot_d = gbx_slot_next(slot_q);
    end

    // Requests are decoded from the next slot so the registered output lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            req_start_q <= 1'b0;
            req_stall_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            req_start_q <= (slot_d == START_SLOT);
            req_stall_q <= (slot_d == STALL_SLOT);
        end
    end

    assign slot_o      = slot_q;
    assign req_start_o = req_start_q;
    assign req_stall_o = req_stall_q;

endmodule

`default_nettype wire

// File: rtl/taxi_eth_phy_10g_tx_gbx_66_64.sv
// +----------------------------------------------------------------------+
// | taxi_eth_phy_10g_tx_gbx_66_64: 66:64 TX gearbox, 32 blocks -> 33     |
// | words. Optional macro TAXI_TX_GBX_STAT_CNT_EN adds status counters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module taxi_eth_phy_10g_tx_gbx_66_64
    import taxi_eth_phy_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int HDR_W      = 2,
    parameter int STALL_LEAD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] serdes_tx_data,
    input  logic              serdes_tx_data_valid,
    input  logic [HDR_W-1:0]  serdes_tx_hdr,
    input  logic              serdes_tx_hdr_valid,
    input  logic              serdes_tx_gbx_start,
    output logic              serdes_tx_gbx_req_start,
    output logic              serdes_tx_gbx_req_stall,
    output logic [DATA_W-1:0] gbx_tx_data,
    output logic              gbx_tx_data_valid,
    output logic              stat_tx_gbx_underflow,
    output logic              stat_tx_gbx_overflow,
    output logic              stat_tx_gbx_seq_err
`ifdef TAXI_TX_GBX_STAT_CNT_EN
    ,
    output logic [15:0]       stat_underflow_cnt,
    output logic [15:0]       stat_overflow_cnt,
    output logic [15:0]       stat_seq_err_cnt
`endif
);

    if (DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "DATA_W must be 64");
    end
    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "HDR_W must be 2");
    end

    logic [5:0] slot;
    logic       last_slot;

    taxi_eth_gbx_seq #(
        .STALL_LEAD (STALL_LEAD)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_o      (slot),
        .req_start_o (serdes_tx_gbx_req_start),
        .req_stall_o (serdes_tx_gbx_req_stall)
    );

    // Header validity is not tracked separately; data_valid qualifies the block.
    logic unused_hdr_valid;
    assign unused_hdr_valid = serdes_tx_hdr_valid;

    logic [GBX_BLOCK_W-1:0] blk;
    logic [6:0]             shamt;
    logic [127:0]           packed_w;
    logic [127:0]           residual_q;
    logic [127:0]           residual_d;
    logic [63:0]            data_q;
    logic [63:0]            data_d;
    logic                   valid_q;
    logic                   uf_q;
    logic                   uf_d;
    logic                   of_q;
    logic                   of_d;
    logic                   se_q;
    logic                   se_d;

    assign last_slot = (slot == gbx_slot_t'(GBX_LAST_SLOT));
    assign blk       = serdes_tx_data_valid ? {serdes_tx_data, serdes_tx_hdr} : '0;
    assign shamt     = {slot, 1'b0};
    assign packed_w  = ({62'b0, blk} << shamt) | residual_q;

    always_comb begin
        residual_d = '0;
        data_d     = residual_q[63:0];
        if (!last_slot) begin
            data_d     = packed_w[63:0];
            residual_d = {64'b0, packed_w[127:64]};
        end
        uf_d = !last_slot && !serdes_tx_data_valid;
        of_d = last_slot && serdes_tx_data_valid;
        se_d = serdes_tx_gbx_start && serdes_tx_data_valid && (slot != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residual_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            uf_q       <= 1'b0;
            of_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            residual_q <= residual_d;
            data_q     <= data_d;
            valid_q    <= 1'b1;
            uf_q       <= uf_d;
            of_q       <= of_d;
            se_q       <= se_d;
        end
    end

    assign gbx_tx_data           = data_q;
    assign gbx_tx_data_valid     = valid_q;
    assign stat_tx_gbx_underflow = uf_q;
    assign stat_tx_gbx_overflow  = of_q;
    assign stat_tx_gbx_seq_err   = se_q;

`ifdef TAXI_TX_GBX_STAT_CNT_EN
    logic [15:0] uf_cnt_q;
    logic [15:0] of_cnt_q;
    logic [15:0] se_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q <= '0;
            of_cnt_q <= '0;
            se_cnt_q <= '0;
        end else begin
            if (uf_d && uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
            if (of_d && of_cnt_q != 16'hFFFF) of_cnt_q <= of_cnt_q + 16'd1;
            if (se_d && se_cnt_q != 16'hFFFF) se_cnt_q <= se_cnt_q + 16'd1;
        end
    end

    assign stat_underflow_cnt = uf_cnt_q;
    assign stat_overflow_cnt  = of_cnt_q;
    assign stat_seq_err_cnt   = se_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_taxi_eth_phy_10g_tx_gbx_66_64.sv
// +----------------------------------------------------------------------+
// | tb_taxi_eth_phy_10g_tx_gbx_66_64: directed bench for the TX gearbox  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_taxi_eth_phy_10g_tx_gbx_66_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] d;
    logic [1:0]  h;
    logic        dv;
    logic        hv;
    logic        st;

    logic        req_start, req_stall, ovalid, uf, of, se;
    logic [63:0] odata;
    logic        req_start3, req_stall3, ovalid3, uf3, of3, se3;
    logic [63:0] odata3;
`ifdef TAXI_TX_GBX_STAT_CNT_EN
    logic [15:0] uf_cnt, of_cnt, se_cnt, uf_cnt3, of_cnt3, se_cnt3;
`endif

    always #5 clk = ~clk;

    taxi_eth_phy_10g_tx_gbx_66_64 #(.STALL_LEAD(1)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .serdes_tx_data          (d),
        .serdes_tx_data_valid    (dv),
        .serdes_tx_hdr           (h),
        .serdes_tx_hdr_valid     (hv),
        .serdes_tx_gbx_start     (st),
        .serdes_tx_gbx_req_start (req_start),
        .serdes_tx_gbx_req_stall (req_stall),
        .gbx_tx_data             (odata),
        .gbx_tx_data_valid       (ovalid),
        .stat_tx_gbx_underflow   (uf),
        .stat_tx_gbx_overflow    (of),
        .stat_tx_gbx_seq_err     (se)
`ifdef TAXI_TX_GBX_STAT_CNT_EN
        ,
        .stat_underflow_cnt      (uf_cnt),
        .stat_overflow_cnt       (of_cnt),
        .stat_seq_err_cnt        (se_cnt)
`endif
    );

    taxi_eth_phy_10g_tx_gbx_66_64 #(.STALL_LEAD(3)) dut3 (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .serdes_tx_data          (d),
        .serdes_tx_data_valid    (dv),
        .serdes_tx_hdr           (h),
        .serdes_tx_hdr_valid     (hv),
        .serdes_tx_gbx_start     (st),
        .serdes_tx_gbx_req_start (req_start3),
        .serdes_tx_gbx_req_stall (req_stall3),
        .gbx_tx_data             (odata3),
        .gbx_tx_data_valid       (ovalid3),
        .stat_tx_gbx_underflow   (uf3),
        .stat_tx_gbx_overflow    (of3),
        .stat_tx_gbx_seq_err     (se3)
`ifdef TAXI_TX_GBX_STAT_CNT_EN
        ,
        .stat_underflow_cnt      (uf_cnt3),
        .stat_overflow_cnt       (of_cnt3),
        .stat_seq_err_cnt        (se_cnt3)
`endif
    );

`ifdef TAXI_TX_GBX_STAT_CNT_EN
    localparam int N_SEQ = 200;
`else
    localparam int N_SEQ = 1000;
`endif

    int   checks = 0;
    int   errors = 0;
    int   slot   = 0;
    bit   bitq[$];
    logic last_stall = 1'b0;
    logic last_start = 1'b0;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  h;
        logic        v;
        logic        s;
        logic [63:0] w;
        logic        uf;
        logic        of;
        logic        se;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (slot %0d)", name, act, exp, slot);
        end
    endtask

    // One slot: drive inputs at the falling edge, check the registered result one edge later.
    task automatic cyc(input logic [63:0] di, input logic [1:0] hi, input logic v, input logic s);
        logic [65:0] blk;
        logic [63:0] exp_w;
        logic        euf, eof, ese;
        chk("req_stall",    req_stall,  slot == 31);
        chk("req_start",    req_start,  slot == 32);
        chk("req_stall_l3", req_stall3, slot == 29);
        chk("req_start_l3", req_start3, slot == 30);
        last_stall = req_stall;
        last_start = req_start;
        d  = di;
        h  = hi;
        dv = v;
        hv = v;
        st = s;
        blk = v ? {di, hi} : 66'b0;
        if (slot < 32) begin
            for (int i = 0; i < 66; i++) bitq.push_back(blk[i]);
        end
        euf = (slot < 32) && !v;
        eof = (slot == 32) && v;
        ese = s && v && (slot != 0);
        @(posedge clk);
        @(negedge clk);
        exp_w = '0;
        for (int i = 0; i < 64; i++) begin
            if (bitq.size() > 0) exp_w[i] = bitq.pop_front();
        end
        chk("word",      odata,  exp_w);
        chk("valid",     ovalid, 1'b1);
        chk("underflow", uf,     euf);
        chk("overflow",  of,     eof);
        chk("seq_err",   se,     ese);
        slot = (slot == 32) ? 0 : slot + 1;
    endtask

    // Well-behaved upstream: random blocks, obeying the previous cycle's requests.
    task automatic run_cycles(input int n);
        logic [63:0] rd;
        logic [1:0]  rh;
        for (int k = 0; k < n; k++) begin
            rd = {$urandom, $urandom};
            rh = 2'($urandom);
            cyc(rd, rh, !last_stall, last_start);
        end
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 40 && slot != target; k++) run_cycles(1);
        chk("run_to_slot", 64'(slot), 64'(target));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},      odata,     64'h0);
        chk({tag, "_valid"},     ovalid,    1'b0);
        chk({tag, "_uf"},        uf,        1'b0);
        chk({tag, "_of"},        of,        1'b0);
        chk({tag, "_se"},        se,        1'b0);
        chk({tag, "_req_start"}, req_start, 1'b0);
        chk({tag, "_req_stall"}, req_stall, 1'b0);
        chk({tag, "_data_l3"},   odata3,    64'h0);
    endtask

    initial begin
        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'h0,                   2'b10, 1'b1, 1'b0, 64'h0000_0000_0000_000B, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{64'h1,                   2'b01, 1'b1, 1'b0, 64'h0000_0000_0000_0050, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{64'h1234_5678_9ABC_DEF0, 2'b11, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0};
        tbl[4] = '{64'h8000_0000_0000_0000, 2'b11, 1'b1, 1'b1, 64'h0000_0000_0000_0300, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{64'h0,                   2'b00, 1'b1, 1'b0, 64'h0000_0000_0000_0200, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{64'h0,                   2'b00, 1'b1, 1'b0, 64'h0000_0000_0000_3FFF, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        d = '0; h = '0; dv = 1'b0; hv = 1'b0; st = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        slot  = 0;

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].d, tbl[i].h, tbl[i].v, tbl[i].s);
            chk($sformatf("tbl%0d_word", i), odata, tbl[i].w);
            chk($sformatf("tbl%0d_uf", i),   uf,    tbl[i].uf);
            chk($sformatf("tbl%0d_of", i),   of,    tbl[i].of);
            chk($sformatf("tbl%0d_se", i),   se,    tbl[i].se);
        end

        run_cycles(N_SEQ * 33);

        run_to(32);
        cyc({$urandom, $urandom}, 2'b10, 1'b1, 1'b0);
        chk("ovf_pulse", of, 1'b1);
        run_cycles(33);

        run_to(5);
        cyc({$urandom, $urandom}, 2'b01, 1'b0, 1'b0);
        chk("udf_pulse", uf, 1'b1);
        run_cycles(33);

        run_to(7);
        cyc({$urandom, $urandom}, 2'b01, 1'b1, 1'b1);
        chk("seq_err_pulse", se, 1'b1);
        run_cycles(33);

`ifdef TAXI_TX_GBX_STAT_CNT_EN
        chk("cnt_uf_pre", uf_cnt, 16'd2);
        chk("cnt_of_pre", of_cnt, 16'd1);
        chk("cnt_se_pre", se_cnt, 16'd2);
`endif

        run_to(17);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        chk_zero("midreset_hold");
        rst_n = 1'b1;
        bitq.delete();
        slot       = 0;
        last_stall = 1'b0;
        last_start = 1'b0;
        run_cycles(66);

`ifdef TAXI_TX_GBX_STAT_CNT_EN
        chk("cnt_uf_clr", uf_cnt, 16'd0);
        chk("cnt_of_clr", of_cnt, 16'd0);
        chk("cnt_se_clr", se_cnt, 16'd0);
        for (int k = 0; k < 70000; k++) cyc(64'h0, 2'b00, 1'b0, 1'b0);
        chk("cnt_uf_sat", uf_cnt, 16'hFFFF);
        chk("cnt_of_sat", of_cnt, 16'd0);
        chk("cnt_se_sat", se_cnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
